// File: rtl/frame_sync_defs.sv
// Shared frame-sync definitions: state encodings and period/width helpers
// used by the synchronizer and neighbouring blocks in the chain.
package frame_sync_defs;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } fs_state_e;

    localparam int DEF_PREAMBLE_LEN = 8;
    localparam int DEF_FRAME_LEN    = 64;

    function automatic int frame_period(input int preamble_len, input int frame_len);
        return preamble_len + frame_len;
    endfunction

    // $clog2 clamped to at least one bit so degenerate counts still get a flop
    function automatic int min1_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_delay_line.sv
// Enable-gated serial delay line; tap is the bit shifted in DEPTH enables ago.
module bit_delay_line #(
    parameter int DEPTH = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din,
    output logic tap
);

    logic [DEPTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (en) begin
            sr_d[0] = din;
            for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

    assign tap = sr_q[DEPTH-1];

endmodule

// File: rtl/frame_sync_fsm.sv
// HUNT/VERIFY/LOCK frame synchronizer with flywheel tolerance of missed
// preambles; forwards only payload bits, marking each frame start.
module frame_sync_fsm
    import frame_sync_defs::*;
#(
    parameter int PREAMBLE_LEN = DEF_PREAMBLE_LEN,
    parameter int FRAME_LEN    = DEF_FRAME_LEN,
    parameter int DATA_DELAY   = 6,
    parameter int VERIFY_CNT   = 2,
    parameter int MISS_CNT     = 3
) (
    input  logic CLK,
    input  logic RESET,
    input  logic DATA_IN,
    input  logic DATA_IN_VALID,
    input  logic DETECT_IN,
    input  logic DETECT_IN_VALID,
    output logic DATA_OUT,
    output logic DATA_OUT_VALID,
    output logic FRAME_START,
    output logic LOCKED
);

    localparam int P  = frame_period(PREAMBLE_LEN, FRAME_LEN);
    localparam int PW = min1_clog2(P);
    localparam int HW = min1_clog2(VERIFY_CNT + 1);
    localparam int MW = min1_clog2(MISS_CNT + 1);

    fs_state_e       state_q, state_d;
    logic [PW-1:0]   pos_q, pos_d, pos_next;
    logic [HW-1:0]   hit_q, hit_d, hit_inc;
    logic [MW-1:0]   miss_q, miss_d, miss_inc;
    logic            dout_q, dout_d;
    logic            dov_q, dov_d;
    logic            fs_q, fs_d;
    logic            lock_q, lock_d;
    logic            tap, at_zero, emit;

    bit_delay_line #(.DEPTH(DATA_DELAY)) u_dly (
        .clk (CLK),
        .rst (RESET),
        .en  (DATA_IN_VALID),
        .din (DATA_IN),
        .tap (tap)
    );

    assign at_zero  = (pos_q == '0);
    assign pos_next = (pos_q == PW'(P-1)) ? '0 : pos_q + PW'(1);
    assign hit_inc  = hit_q + HW'(1);
    assign miss_inc = miss_q + MW'(1);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        lock_d  = lock_q;
        emit    = 1'b0;
        dout_d  = 1'b0;
        dov_d   = 1'b0;
        fs_d    = 1'b0;
        if (DETECT_IN_VALID) begin
            pos_d = pos_next;
            unique case (state_q)
                // pos is held at 0 while hunting, so a hit makes this sample index 0
                HUNT: begin
                    if (DETECT_IN) begin
                        hit_d = HW'(1);
                        if (VERIFY_CNT == 1) begin
                            state_d = LOCK;
                            miss_d  = '0;
                            emit    = 1'b1;
                        end else begin
                            state_d = VERIFY;
                        end
                    end else begin
                        pos_d = '0;
                    end
                end
                VERIFY: begin
                    if (at_zero) begin
                        if (!DETECT_IN) begin
                            state_d = HUNT;
                            pos_d   = '0;
                            hit_d   = '0;
                        end else if (hit_inc == HW'(VERIFY_CNT)) begin
                            state_d = LOCK;
                            miss_d  = '0;
                            emit    = 1'b1;
                        end else begin
                            hit_d = hit_inc;
                        end
                    end
                end
                LOCK: begin
                    if (!at_zero) begin
                        emit = (pos_q < PW'(FRAME_LEN));
                    end else if (DETECT_IN) begin
                        miss_d = '0;
                        emit   = 1'b1;
                    end else if (miss_inc == MW'(MISS_CNT)) begin
                        state_d = HUNT;
                        pos_d   = '0;
                        hit_d   = '0;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_inc;
                        emit   = 1'b1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    pos_d   = '0;
                    hit_d   = '0;
                    miss_d  = '0;
                end
            endcase
            dov_d  = emit;
            dout_d = emit & tap;
            fs_d   = emit & at_zero;
            lock_d = (state_d == LOCK);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= HUNT;
            pos_q   <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            dout_q  <= 1'b0;
            dov_q   <= 1'b0;
            fs_q    <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            dout_q  <= dout_d;
            dov_q   <= dov_d;
            fs_q    <= fs_d;
            lock_q  <= lock_d;
        end
    end

    assign DATA_OUT       = dout_q;
    assign DATA_OUT_VALID = dov_q;
    assign FRAME_START    = fs_q;
    assign LOCKED         = lock_q;

endmodule

// File: doc/frame_sync_fsm.md
# frame_sync_fsm

Frame synchronizer that sits directly downstream of the preamble finder in the Frame_Sync chain. It consumes the finder's per-sample detect decision together with the raw bit stream, and runs a HUNT/VERIFY/LOCK state machine with flywheel tolerance of missed preambles. It emits only payload bits, with a frame-start marker and a lock status, to the decoder stage.

## Interface
Parameters:
- PREAMBLE_LEN, 8: preamble length in bits.
- FRAME_LEN, 64: payload bits per frame. Frame period P = PREAMBLE_LEN + FRAME_LEN samples.
- DATA_DELAY, 6: data delay-line depth in valid samples. Chosen so the tap read on a DETECT_IN=1 sample is the first payload bit after that preamble.
- VERIFY_CNT, 2: consecutive on-time preamble hits, including the first, required to lock.
- MISS_CNT, 3: consecutive on-time preamble misses that drop lock.

Ports:
- CLK, in, 1: single clock.
- RESET, in, 1: synchronous, active-high reset.
- DATA_IN, in, 1: raw serial bit, the same stream that feeds the preamble finder.
- DATA_IN_VALID, in, 1: DATA_IN qualifier.
- DETECT_IN, in, 1: preamble finder decision.
- DETECT_IN_VALID, in, 1: decision qualifier. Exactly one assertion per DATA_IN_VALID, one cycle later. This defines a "sample".
- DATA_OUT, out, 1: payload bit.
- DATA_OUT_VALID, out, 1: DATA_OUT qualifier.
- FRAME_START, out, 1: high with the first payload bit of each frame.
- LOCKED, out, 1: high while in LOCK.

## Operation
- Delay line: DATA_DELAY-bit shift register advanced on DATA_IN_VALID. It is read on each DETECT_IN_VALID at tap DATA_DELAY-1.
- Sample counter `pos`, width $clog2(P):
  - Advances once per sample and wraps P-1 -> 0.
  - Index 0 is the sample on which a preamble is expected, or was found.
  - Payload occupies indices 0..FRAME_LEN-1.
- HUNT, the reset state:
  - No output.
  - DETECT_IN=1 -> VERIFY. This sample is index 0 and hit count = 1.
  - If VERIFY_CNT = 1, go directly to LOCK and treat this sample as a LOCK index-0 hit.
- VERIFY:
  - No output. DETECT_IN at nonzero indices is ignored.
  - At index 0 with DETECT_IN=1: hit count increments. Reaching VERIFY_CNT -> LOCK, and this sample is emitted as FRAME_START.
  - At index 0 with DETECT_IN=0: -> HUNT, counters cleared.
- LOCK:
  - Every sample with index < FRAME_LEN emits the tap bit with DATA_OUT_VALID=1. FRAME_START=1 at index 0.
  - At index 0: DETECT_IN=1 clears the miss count. DETECT_IN=0 increments it.
  - When the miss count reaches MISS_CNT: -> HUNT on that sample, that sample is not emitted, and LOCKED drops.
  - Misses below MISS_CNT still emit (flywheel).
  - DETECT_IN at nonzero indices is ignored; there is no re-alignment while locked.
- Counters saturate-free: hit count ≤ VERIFY_CNT and miss count ≤ MISS_CNT by construction. Widths are $clog2(cnt+1).

## Timing
- Reset: DATA_OUT=0, DATA_OUT_VALID=0, FRAME_START=0, LOCKED=0, state=HUNT, all counters and the delay line at 0.
  - RESET mid-frame takes priority over any valid input on the same cycle.
  - The first sample after reset is processed normally.
- All outputs are registered. The response to a sample appears one CLK after DETECT_IN_VALID.
- DATA_OUT_VALID and FRAME_START are single-cycle pulses per sample. Both are 0 on cycles with no DETECT_IN_VALID.
- LOCKED rises in the same cycle as the first FRAME_START. It falls in the cycle that would have carried the MISS_CNT-th missed index-0 sample.
- DETECT_IN_VALID gaps simply stall `pos`. Throughput is one payload bit per sample.

## Structure
- Shared package/header frame_sync_defs: state encodings (HUNT=2'd0, VERIFY=2'd1, LOCK=2'd2) and the P/width helper constants. The preamble finder and downstream blocks use these too.
- Sub-module bit_delay_line (parameter DEPTH): enable-gated shift register with synchronous reset, instantiated for the data alignment.
- FSM, `pos`, and hit/miss counters live in frame_sync_fsm.

## Test plan
- Clean stream, defaults: 5 frames of preamble 8'b01110011 followed by 64 random bits, with DETECT_IN driven by a model finder -> LOCKED rises at the second preamble. Exactly 64 payload bits per frame follow, each matching the sent bits, FRAME_START on each first bit, 4 frames output.
- False hit in HUNT: a single isolated DETECT_IN=1 with no repeat after P=72 samples -> VERIFY then back to HUNT. DATA_OUT_VALID never asserts.
- Flywheel: locked stream, then suppress DETECT_IN on 2 consecutive expected preambles -> output continues unbroken and LOCKED stays 1. A third suppression -> LOCKED=0 on that sample with no emission.
- Gapped valids: DATA_IN_VALID asserted every 3rd cycle -> identical payload bits and frame boundaries as the dense run. Outputs pulse only one cycle after each DETECT_IN_VALID.
- Reset mid-frame: assert RESET at payload bit 30 while locked -> all outputs 0 next cycle. Relock requires 2 fresh on-time preambles.
- VERIFY_CNT=1, MISS_CNT=1 build: the first preamble locks immediately with FRAME_START on that sample. The first missed preamble unlocks.
